carfield_l2_scrub_ctrl: RTL and testbench
=========================================

CARFIELD_L2_SCRUB_CTRL -- requirements
Module: carfield_l2_scrub_ctrl

Interface
REQ-001 The block SHALL have parameter BaseAddr, default 48'h7800_0000, byte address of the scrubbed L2 port window.
REQ-002 The block SHALL have parameter NumWords, default 262144, number of 64-bit words in the window (2 MiB).
REQ-003 The block SHALL have parameter CntWidth, default 16, width of the error counters.
REQ-004 Clocking and reset SHALL be one clock and an asynchronous, active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-005 The block SHALL have port en_i  in  1  scrubbing enable.
REQ-006 The block SHALL have port interval_i  in  16  idle cycles between scrub accesses.
REQ-007 The block SHALL have port busy_i  in  1  functional traffic is pending on the port, so the scrubber yields.
REQ-008 The block SHALL have ports req_o  out  1, gnt_i  in  1, we_o  out  1, addr_o  out  48, wdata_o  out  64: the memory request channel.
REQ-009 The block SHALL have ports rvalid_i  in  1, rdata_i  in  64 (ECC-corrected data), ecc_corr_i  in  1, ecc_uncorr_i  in  1: the read response channel.
REQ-010 The block SHALL have ports corr_cnt_o  out  CntWidth and uncorr_cnt_o  out  CntWidth: saturating error counters.
REQ-011 The block SHALL have ports clr_cnt_i  in  1 (clear counters), irq_o  out  1 (uncorrectable-error interrupt), sweep_done_o  out  1 (one-cycle pulse per full pass) and idx_o  out  log2(NumWords) (current word index).

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT, RD_REQ, RD_RESP and WR_REQ.
REQ-013 In IDLE with en_i=1, the FSM SHALL go to WAIT on the next cycle and load the timer with interval_i.
REQ-014 In WAIT, while the timer is nonzero, the timer SHALL decrement by one each cycle.
REQ-015 In WAIT with timer=0, en_i=1 and busy_i=0, the FSM SHALL go to RD_REQ; a WAIT therefore lasts at least interval_i+1 cycles.
REQ-016 In WAIT with timer=0 and busy_i=1, the FSM SHALL hold with the timer at 0.
REQ-017 In WAIT with en_i=0, the FSM SHALL go to IDLE.
REQ-018 In RD_REQ, outputs SHALL be req_o=1, we_o=0, addr_o=BaseAddr+8*idx.
REQ-019 Once req_o is asserted, it SHALL hold, with addr_o, we_o and wdata_o stable, until gnt_i=1, regardless of busy_i or en_i.
REQ-020 On a grant in RD_REQ, the FSM SHALL go to RD_RESP.
REQ-021 In RD_RESP, the FSM SHALL wait for rvalid_i=1 with req_o=0.
REQ-022 On rvalid_i with ecc_uncorr_i=1, the FSM SHALL increment uncorr_cnt_o, advance idx and go to WAIT; no write-back SHALL occur, and ecc_corr_i SHALL be ignored.
REQ-023 On rvalid_i with ecc_corr_i=1 and ecc_uncorr_i=0, the FSM SHALL increment corr_cnt_o, capture rdata_i into wdata_o and go to WR_REQ.
REQ-024 On rvalid_i with neither error flag set, the FSM SHALL advance idx and go to WAIT.
REQ-025 In WR_REQ, outputs SHALL be req_o=1, we_o=1, with the same addr_o as the preceding read.
REQ-026 On a grant in WR_REQ, the FSM SHALL advance idx and go to WAIT; writes SHALL produce no response, and any rvalid_i outside RD_RESP SHALL be ignored.
REQ-027 Every entry to WAIT SHALL reload the timer with interval_i.
REQ-028 Advancing from idx=NumWords-1 SHALL wrap idx to 0 and pulse sweep_done_o high for exactly one cycle, in the cycle after the advance.
REQ-029 Deasserting en_i SHALL not abort an in-flight transaction: RD_REQ, RD_RESP and WR_REQ complete and the FSM then goes to IDLE.
REQ-030 idx SHALL be retained across an en_i toggle, and scrubbing SHALL resume at the retained index.
REQ-031 The counters SHALL saturate at all-ones and not wrap.
REQ-032 clr_cnt_i=1 SHALL zero both counters on the next cycle.
REQ-033 When clr_cnt_i coincides with an increment, the clear SHALL win and the increment SHALL be dropped.
REQ-034 irq_o SHALL be combinationally equal to (uncorr_cnt_o != 0).

Reset
REQ-035 While rst_ni=0, asynchronously, the block SHALL set: state=IDLE, timer=0, idx=0, req_o=0, we_o=0, addr_o=BaseAddr, wdata_o=0, both counters=0, irq_o=0, sweep_done_o=0.
REQ-036 A reset asserted mid-transaction SHALL drop req_o immediately, and no pending response SHALL be tracked after reset release.

Verification
REQ-037 Scenario: en_i=1, interval_i=3, busy_i=0, gnt_i granted one cycle after req_o, clean responses -> reads at 0x7800_0000, 0x7800_0008, 0x7800_0010, with successive RD_REQ entries exactly 4 WAIT cycles apart (plus access time).
REQ-038 Scenario: read of idx 5 returns ecc_corr_i=1, rdata_i=64'hDEAD_BEEF_0000_0005 -> corr_cnt_o=1, then a write to 0x7800_0028 with wdata_o=64'hDEAD_BEEF_0000_0005, then idx_o=6.
REQ-039 Scenario: ecc_uncorr_i=1 and ecc_corr_i=1 returned together -> uncorr_cnt_o=1, irq_o=1, corr_cnt_o unchanged, no write; then clr_cnt_i pulse -> both counters 0 and irq_o=0.
REQ-040 Scenario: busy_i=1 held for 20 cycles with timer=0 -> req_o stays 0 throughout. Scenario: busy_i rises while req_o=1 and gnt_i is delayed 5 cycles -> req_o and addr_o stay stable until the grant.
REQ-041 Scenario: NumWords=4, clean sweep -> sweep_done_o pulses once per 4 reads and addr_o wraps to BaseAddr. Scenario: en_i dropped during RD_RESP -> response consumed, then IDLE, then resume at the next idx when en_i=1.
REQ-042 Scenario: CntWidth=2, 5 corrected errors -> corr_cnt_o=3. Scenario: rst_ni pulsed low during WR_REQ -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/carfield_l2_scrub_ctrl.sv
// Background L2 ECC scrubber: walks the window one 64-bit word at a time, reads each
// word, writes corrected data back and counts correctable/uncorrectable errors.
module carfield_l2_scrub_ctrl #(
  parameter logic [47:0] BaseAddr = 48'h7800_0000,
  parameter int unsigned NumWords = 262144,
  parameter int unsigned CntWidth = 16,
  localparam int unsigned IdxW    = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [15:0]         interval_i,
  input  logic                busy_i,
  output logic                req_o,
  input  logic                gnt_i,
  output logic                we_o,
  output logic [47:0]         addr_o,
  output logic [63:0]         wdata_o,
  input  logic                rvalid_i,
  input  logic [63:0]         rdata_i,
  input  logic                ecc_corr_i,
  input  logic                ecc_uncorr_i,
  output logic [CntWidth-1:0] corr_cnt_o,
  output logic [CntWidth-1:0] uncorr_cnt_o,
  input  logic                clr_cnt_i,
  output logic                irq_o,
  output logic                sweep_done_o,
  output logic [IdxW-1:0]     idx_o
);

  typedef enum logic [2:0] {IDLE, WAIT, RD_REQ, RD_RESP, WR_REQ} state_e;

  state_e          state;
  logic [15:0]     timer;
  logic [IdxW-1:0] idx_nxt;
  logic            idx_wrap;
  logic            adv;

  assign idx_wrap = (idx_o == IdxW'(NumWords - 1));
  assign idx_nxt  = idx_wrap ? '0 : idx_o + IdxW'(1);

  // The word is finished after a clean/uncorrectable read, or once the repair write is granted.
  assign adv = ((state == RD_RESP) && rvalid_i && (ecc_uncorr_i || !ecc_corr_i)) ||
               ((state == WR_REQ) && gnt_i);

  // Address follows the word index only, so it cannot move while a request is pending.
  assign addr_o = BaseAddr + (48'(idx_o) << 3);
  assign irq_o  = (uncorr_cnt_o != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      timer        <= '0;
      idx_o        <= '0;
      req_o        <= 1'b0;
      we_o         <= 1'b0;
      wdata_o      <= '0;
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
      sweep_done_o <= 1'b0;
    end else begin
      sweep_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en_i) begin
            state <= WAIT;
            timer <= interval_i;
          end
        end
        WAIT: begin
          if (!en_i) begin
            state <= IDLE;
          end else if (timer != '0) begin
            timer <= timer - 16'd1;
          end else if (!busy_i) begin
            state <= RD_REQ;
            req_o <= 1'b1;
            we_o  <= 1'b0;
          end
        end
        RD_REQ: begin
          if (gnt_i) begin
            state <= RD_RESP;
            req_o <= 1'b0;
          end
        end
        RD_RESP: begin
          if (rvalid_i) begin
            if (ecc_uncorr_i) begin
              if (uncorr_cnt_o != '1) uncorr_cnt_o <= uncorr_cnt_o + CntWidth'(1);
            end else if (ecc_corr_i) begin
              if (corr_cnt_o != '1) corr_cnt_o <= corr_cnt_o + CntWidth'(1);
              wdata_o <= rdata_i;
              state   <= WR_REQ;
              req_o   <= 1'b1;
              we_o    <= 1'b1;
            end
          end
        end
        WR_REQ: ;
        default: state <= IDLE;
      endcase

      if (adv) begin
        idx_o        <= idx_nxt;
        sweep_done_o <= idx_wrap;
        state        <= en_i ? WAIT : IDLE;
        timer        <= interval_i;
        req_o        <= 1'b0;
        we_o         <= 1'b0;
      end

      // A clear overrides any increment landing in the same cycle.
      if (clr_cnt_i) begin
        corr_cnt_o   <= '0;
        uncorr_cnt_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_carfield_l2_scrub_ctrl.sv
// Directed bench for the L2 scrubber: memory responder, phase-level reference model,
// per-cycle output compare and hand-computed literal checks per scenario.
module tb_carfield_l2_scrub_ctrl;
  localparam logic [47:0] BASE = 48'h7800_0000;
  localparam int NW   = 8;
  localparam int CW   = 2;
  localparam int IW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i, busy_i, gnt_i, rvalid_i, ecc_corr_i, ecc_uncorr_i, clr_cnt_i;
  logic [15:0]   interval_i;
  logic [63:0]   rdata_i;
  logic          req_o, we_o, irq_o, sweep_done_o;
  logic [47:0]   addr_o;
  logic [63:0]   wdata_o;
  logic [CW-1:0] corr_cnt_o, uncorr_cnt_o;
  logic [IW-1:0] idx_o;

  carfield_l2_scrub_ctrl #(.BaseAddr(BASE), .NumWords(NW), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .interval_i(interval_i), .busy_i(busy_i),
    .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .ecc_corr_i(ecc_corr_i), .ecc_uncorr_i(ecc_uncorr_i),
    .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o), .clr_cnt_i(clr_cnt_i), .irq_o(irq_o),
    .sweep_done_o(sweep_done_o), .idx_o(idx_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting, 2 read request, 3 read response, 4 write request.
  int          m_ph = 0, m_waited = 0, m_idx = 0, m_corr = 0, m_unc = 0;
  logic [15:0] m_int = '0;
  logic [63:0] m_wdata = '0;
  bit          m_sweep = 0, m_adv, m_ic, m_iu;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_ph = 0; m_waited = 0; m_idx = 0; m_corr = 0; m_unc = 0;
      m_int = '0; m_wdata = '0; m_sweep = 0;
    end else begin
      m_adv = 0; m_ic = 0; m_iu = 0; m_sweep = 0;
      case (m_ph)
        0: if (en_i) begin m_ph = 1; m_waited = 0; m_int = interval_i; end
        1: begin
          if (!en_i) m_ph = 0;
          else if (m_waited >= int'(m_int) && !busy_i) m_ph = 2;
          else m_waited++;
        end
        2: if (gnt_i) m_ph = 3;
        3: if (rvalid_i) begin
          if (ecc_uncorr_i) begin m_iu = 1; m_adv = 1; end
          else if (ecc_corr_i) begin m_ic = 1; m_wdata = rdata_i; m_ph = 4; end
          else m_adv = 1;
        end
        4: if (gnt_i) m_adv = 1;
        default: ;
      endcase
      if (m_adv) begin
        m_sweep  = (m_idx == NW - 1);
        m_idx    = (m_idx + 1) % NW;
        m_ph     = en_i ? 1 : 0;
        m_waited = 0;
        m_int    = interval_i;
      end
      if (clr_cnt_i) begin
        m_corr = 0; m_unc = 0;
      end else begin
        if (m_ic && m_corr < CMAX) m_corr++;
        if (m_iu && m_unc < CMAX) m_unc++;
      end
    end
  end

  int sweep_cnt = 0;
  always @(posedge clk) begin
    #1;
    chk("req", 64'(req_o), 64'(m_ph == 2 || m_ph == 4));
    chk("we", 64'(we_o), 64'(m_ph == 4));
    chk("addr", 64'(addr_o), 64'(BASE + 48'(m_idx * 8)));
    chk("idx", 64'(idx_o), 64'(m_idx));
    chk("corr_cnt", 64'(corr_cnt_o), 64'(m_corr));
    chk("uncorr_cnt", 64'(uncorr_cnt_o), 64'(m_unc));
    chk("wdata", wdata_o, m_wdata);
    chk("sweep", 64'(sweep_done_o), 64'(m_sweep));
    chk("irq", 64'(irq_o), 64'(m_unc != 0));
    if (sweep_done_o) sweep_cnt++;
  end

  // Memory responder: grants after gnt_dly extra cycles, answers reads rv_dly cycles later.
  int          gnt_dly = 1, rv_dly = 1;
  int          err_map [NW];
  int          gcnt = 0, rvc = 0, rd_word = 0, hold_len = 0, cyc = 0;
  bit          rd_pend = 0;
  int          rd_count = 0, wr_count = 0, rsp_count = 0;
  logic [47:0] rd_addr [$];
  int          rd_time [$];
  logic [47:0] last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;

  always @(posedge clk) cyc++;

  initial begin
    gnt_i = 0; rvalid_i = 0; rdata_i = '0; ecc_corr_i = 0; ecc_uncorr_i = 0;
    forever begin
      @(negedge clk);
      gnt_i = 0; rvalid_i = 0; ecc_corr_i = 0; ecc_uncorr_i = 0;
      if (!rst_ni) begin
        gcnt = 0; rd_pend = 0;
      end else begin
        if (rd_pend) begin
          if (rvc == rv_dly) begin
            rvalid_i     = 1;
            rdata_i      = 64'hDEAD_BEEF_0000_0000 | 64'(rd_word);
            ecc_corr_i   = err_map[rd_word][0];
            ecc_uncorr_i = err_map[rd_word][1];
            rd_pend      = 0;
            rsp_count++;
          end else rvc++;
        end
        if (req_o) begin
          if (gcnt == gnt_dly) begin
            gnt_i = 1; hold_len = gcnt + 1; gcnt = 0;
            if (we_o) begin
              wr_count++; last_wr_addr = addr_o; last_wr_data = wdata_o;
            end else begin
              rd_pend = 1; rvc = 0;
              rd_word = int'((addr_o - BASE) >> 3) & (NW - 1);
              rd_addr.push_back(addr_o); rd_time.push_back(cyc); rd_count++;
            end
          end else gcnt++;
        end else gcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  int n0, r0, w0;
  logic [47:0] a0;

  initial begin
    en_i = 0; busy_i = 0; clr_cnt_i = 0; interval_i = 16'd3;
    for (int i = 0; i < NW; i++) err_map[i] = 0;
    err_map[5] = 1;
    err_map[6] = 3;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(req_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'h7800_0000);
    chk("rst_cnt", 64'({corr_cnt_o, uncorr_cnt_o}), 64'd0);
    chk("rst_irq_sweep_idx", 64'({irq_o, sweep_done_o, idx_o}), 64'd0);
    rst_ni = 1;
    @(negedge clk);
    en_i = 1;

    // Clean reads, interval 3, one-cycle grant and response delay.
    for (int i = 0; i < 400 && rd_count < 3; i++) @(negedge clk);
    chk("tmo_reads", 64'(rd_count >= 3), 64'd1);
    if (rd_count >= 3) begin
      chk("rd0_addr", 64'(rd_addr[0]), 64'h7800_0000);
      chk("rd1_addr", 64'(rd_addr[1]), 64'h7800_0008);
      chk("rd2_addr", 64'(rd_addr[2]), 64'h7800_0010);
      chk("rd_spacing1", 64'(rd_time[1] - rd_time[0]), 64'd8);
      chk("rd_spacing2", 64'(rd_time[2] - rd_time[1]), 64'd8);
    end

    // Corrected error at idx 5 -> write-back of corrected data.
    for (int i = 0; i < 400 && wr_count < 1; i++) @(negedge clk);
    chk("wr_addr", 64'(last_wr_addr), 64'h7800_0028);
    chk("wr_data", last_wr_data, 64'hDEAD_BEEF_0000_0005);
    chk("corr_after_wr", 64'(corr_cnt_o), 64'd1);
    for (int i = 0; i < 50 && idx_o != 3'd6; i++) @(negedge clk);
    chk("idx_after_wr", 64'(idx_o), 64'd6);

    // Both flags at idx 6: uncorrectable wins, no write-back, then clear.
    for (int i = 0; i < 200 && uncorr_cnt_o == '0; i++) @(negedge clk);
    chk("uncorr_cnt", 64'(uncorr_cnt_o), 64'd1);
    chk("uncorr_irq", 64'(irq_o), 64'd1);
    chk("uncorr_corr_kept", 64'(corr_cnt_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("uncorr_no_write", 64'(wr_count), 64'd1);
    clr_cnt_i = 1;
    @(negedge clk);
    clr_cnt_i = 0;
    chk("clr_cnt", 64'({corr_cnt_o, uncorr_cnt_o}), 64'd0);
    chk("clr_irq", 64'(irq_o), 64'd0);

    // Wrap from idx 7 to 0.
    for (int i = 0; i < 300 && sweep_cnt < 1; i++) @(negedge clk);
    chk("sweep_once", 64'(sweep_cnt), 64'd1);
    chk("wrap_idx", 64'(idx_o), 64'd0);
    chk("wrap_addr", 64'(addr_o), 64'h7800_0000);
    err_map[5] = 0;
    err_map[6] = 0;

    // busy_i held with the timer expired: no request.
    r0 = rsp_count;
    for (int i = 0; i < 100 && rsp_count == r0; i++) @(negedge clk);
    busy_i = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("busy_noreq", 64'(req_o), 64'd0);
    end

    // Slow grant while busy rises and enable drops: request held until granted.
    gnt_dly = 5;
    busy_i = 0;
    for (int i = 0; i < 20 && !req_o; i++) @(negedge clk);
    busy_i = 1;
    en_i = 0;
    r0 = rsp_count;
    for (int i = 0; i < 50 && rsp_count == r0; i++) @(negedge clk);
    chk("slow_gnt_hold", 64'(hold_len), 64'd6);
    busy_i = 0;
    repeat (6) @(negedge clk);
    chk("idle_after_dis", 64'(req_o), 64'd0);

    // Enable dropped during RD_RESP: response consumed, idle, resume at next idx.
    gnt_dly = 1;
    rv_dly = 4;
    n0 = rd_count;
    en_i = 1;
    for (int i = 0; i < 50 && rd_count <= n0; i++) @(negedge clk);
    en_i = 0;
    a0 = rd_addr[$];
    r0 = rsp_count;
    for (int i = 0; i < 50 && rsp_count == r0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("dis_rsp_idle", 64'(req_o), 64'd0);
    en_i = 1;
    for (int i = 0; i < 50 && rd_count <= n0 + 1; i++) @(negedge clk);
    chk("resume_addr", 64'(rd_addr[$]),
        64'(BASE + 48'(((int'((a0 - BASE) >> 3) + 1) % NW) * 8)));

    // Counter saturation with 2-bit counters.
    rv_dly = 1;
    for (int i = 0; i < NW; i++) err_map[i] = 1;
    clr_cnt_i = 1;
    @(negedge clk);
    clr_cnt_i = 0;
    w0 = wr_count;
    for (int i = 0; i < 600 && wr_count < w0 + 5; i++) @(negedge clk);
    chk("tmo_sat_writes", 64'(wr_count >= w0 + 5), 64'd1);
    chk("corr_saturated", 64'(corr_cnt_o), 64'd3);

    // Reset asserted mid write request.
    gnt_dly = 40;
    for (int i = 0; i < 100 && !(req_o && we_o); i++) @(negedge clk);
    chk("wr_pending", 64'(req_o && we_o), 64'd1);
    repeat (2) @(negedge clk);
    #2;
    rst_ni = 0;
    #1;
    chk("mid_rst_req_we", 64'({req_o, we_o}), 64'd0);
    chk("mid_rst_addr", 64'(addr_o), 64'h7800_0000);
    chk("mid_rst_wdata", wdata_o, 64'd0);
    chk("mid_rst_cnt", 64'({corr_cnt_o, uncorr_cnt_o}), 64'd0);
    chk("mid_rst_misc", 64'({irq_o, sweep_done_o, idx_o}), 64'd0);
    en_i = 0;
    gnt_dly = 1;
    repeat (2) @(negedge clk);
    rst_ni = 1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 64'(req_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
